// File: rtl/data_mem_pkg.sv
// Shared types for the burst data memory: FSM state encoding and width helpers.
package data_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain
    } state_e;

    // A zero-width length field is illegal, so a single-word burst still gets one bit.
    function automatic int unsigned len_width(input int unsigned max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/data_mem_burst_if.sv
// Command, write-data and read-data handshakes of the burst data memory.
interface data_mem_burst_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned LEN_WIDTH  = 3
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy
    );

endinterface

// File: rtl/mem_array.sv
// Word storage with one write port and one registered, enabled read port.
module mem_array #(
    parameter int unsigned Width        = 8,
    parameter int unsigned Depth        = 64,
    parameter int unsigned AddrW        = $clog2(Depth),
    parameter bit          ClearOnReset = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    if (ClearOnReset) begin : g_clear
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < Depth; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
        end
    end else begin : g_keep
        // Contents survive reset so a partially written burst stays readable.
        always_ff @(posedge clk_i) begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_burst.sv
// Burst-oriented data memory: accepts one read or write burst at a time and streams words
// through valid/ready handshakes with wrapping addresses.
module data_mem_burst
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned MEMORY_SIZE    = 64,
    parameter int unsigned MAX_BURST      = 8,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic             clk,
    input logic             reset,
    data_mem_burst_if.slave bus_io
);

    localparam int unsigned AddrW = $clog2(MEMORY_SIZE);
    localparam int unsigned LenW  = len_width(MAX_BURST);

    state_e           state_q;
    logic [AddrW-1:0] addr_q;
    logic [LenW-1:0]  cnt_q;
    logic [LenW-1:0]  len_q;
    logic             rd_valid_q;
    logic             cmd_ready_q;
    logic             wr_ready_q;
    logic             busy_q;

    logic wr_beat;
    logic rd_load;
    logic last_beat;

    assign wr_beat   = (state_q == StWrite) && bus_io.wr_valid;
    // The output register may refill whenever it is empty or being drained this cycle.
    assign rd_load   = (state_q == StRead) && (!rd_valid_q || bus_io.rd_ready);
    assign last_beat = (cnt_q == len_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            rd_valid_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.cmd_valid && cmd_ready_q) begin
                        addr_q      <= bus_io.cmd_addr;
                        len_q       <= bus_io.cmd_len;
                        cnt_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bus_io.cmd_write) begin
                            state_q    <= StWrite;
                            wr_ready_q <= 1'b1;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StWrite: begin
                    if (wr_beat) begin
                        addr_q <= addr_q + AddrW'(1);
                        cnt_q  <= cnt_q + LenW'(1);
                        if (last_beat) begin
                            state_q     <= StIdle;
                            wr_ready_q  <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                StRead: begin
                    if (rd_load) begin
                        rd_valid_q <= 1'b1;
                        addr_q     <= addr_q + AddrW'(1);
                        cnt_q      <= cnt_q + LenW'(1);
                        if (last_beat) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (bus_io.rd_ready) begin
                        rd_valid_q  <= 1'b0;
                        state_q     <= StIdle;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    mem_array #(
        .Width        (DATA_WIDTH),
        .Depth        (MEMORY_SIZE),
        .AddrW        (AddrW),
        .ClearOnReset (CLEAR_ON_RESET)
    ) u_mem_array (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (wr_beat),
        .waddr_i (addr_q),
        .wdata_i (bus_io.wr_data),
        .re_i    (rd_load),
        .raddr_i (addr_q),
        .rdata_o (bus_io.rd_data)
    );

    assign bus_io.cmd_ready = cmd_ready_q;
    assign bus_io.wr_ready  = wr_ready_q;
    assign bus_io.rd_valid  = rd_valid_q;
    assign bus_io.busy      = busy_q;

endmodule

// File: tb/tb_data_mem_burst.sv
// Randomized bench for data_mem_burst: two instances (memory kept / cleared on reset) run in
// lockstep against an array model of the memory contents.
module tb_data_mem_burst;

    localparam int unsigned DW = 8;
    localparam int unsigned MS = 64;
    localparam int unsigned MB = 8;
    localparam int unsigned AW = 6;
    localparam int unsigned LW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_mem_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus_keep ();
    data_mem_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus_clr ();

    assign bus_clr.cmd_valid = bus_keep.cmd_valid;
    assign bus_clr.cmd_write = bus_keep.cmd_write;
    assign bus_clr.cmd_addr  = bus_keep.cmd_addr;
    assign bus_clr.cmd_len   = bus_keep.cmd_len;
    assign bus_clr.wr_valid  = bus_keep.wr_valid;
    assign bus_clr.wr_data   = bus_keep.wr_data;
    assign bus_clr.rd_ready  = bus_keep.rd_ready;

    data_mem_burst #(
        .DATA_WIDTH     (DW),
        .MEMORY_SIZE    (MS),
        .MAX_BURST      (MB),
        .CLEAR_ON_RESET (1'b0)
    ) u_dut_keep (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus_keep)
    );

    data_mem_burst #(
        .DATA_WIDTH     (DW),
        .MEMORY_SIZE    (MS),
        .MAX_BURST      (MB),
        .CLEAR_ON_RESET (1'b1)
    ) u_dut_clr (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus_clr)
    );

    // Reference memories; words of the keep instance are only trusted once written.
    logic [DW-1:0] ref_keep [MS];
    bit            known_keep [MS];
    logic [DW-1:0] ref_clr [MS];

    int n_cmp = 0;
    int n_err = 0;
    bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, bus_keep.cmd_ready, 1);
        check_eq({tag, "_busy"}, bus_keep.busy, 0);
        check_eq({tag, "_wr_ready"}, bus_keep.wr_ready, 0);
        check_eq({tag, "_rd_valid"}, bus_keep.rd_valid, 0);
        check_eq({tag, "_clr_cmd_ready"}, bus_clr.cmd_ready, 1);
        check_eq({tag, "_clr_busy"}, bus_clr.busy, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #3;
        check_idle_outputs("rst");
        check_eq("rst_rd_data", bus_keep.rd_data, 0);
        check_eq("rst_clr_rd_data", bus_clr.rd_data, 0);
        for (int i = 0; i < MS; i++) ref_clr[i] = '0;
        @(negedge clk);
        reset = 1'b1;
        step();
        check_idle_outputs("post_rst");
    endtask

    task automatic send_cmd(input bit wr, input int addr, input int len);
        bit ok;
        bus_keep.cmd_valid = 1'b1;
        bus_keep.cmd_write = wr;
        bus_keep.cmd_addr  = AW'(addr);
        bus_keep.cmd_len   = LW'(len);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bus_keep.cmd_ready;
            step();
        end
        bus_keep.cmd_valid = 1'b0;
        check_eq("cmd_accept", ok, 1);
        check_eq("busy_after_cmd", bus_keep.busy, 1);
        check_eq("cmd_ready_after_cmd", bus_keep.cmd_ready, 0);
    endtask

    // Performs n_beats of a len+1 burst; fewer beats leave the burst open for a reset.
    task automatic write_burst(input int addr, input int len, input int n_beats,
                               input bit use_seq, input logic [DW-1:0] base, input bit poke_cmd);
        logic [DW-1:0] d;
        int a;
        send_cmd(1'b1, addr, len);
        if (poke_cmd) begin
            bus_keep.cmd_valid = 1'b1;
            bus_keep.cmd_write = 1'b0;
        end
        for (int b = 0; b < n_beats; b++) begin
            while ($urandom_range(0, 3) == 0) begin
                bus_keep.wr_valid = 1'b0;
                bus_keep.wr_data  = DW'($urandom);
                step();
            end
            d = use_seq ? DW'(base + DW'(b)) : DW'($urandom);
            bus_keep.wr_valid = 1'b1;
            bus_keep.wr_data  = d;
            check_eq("wr_ready", bus_keep.wr_ready, 1);
            check_eq("cmd_ready_busy", bus_keep.cmd_ready, 0);
            step();
            a = (addr + b) % MS;
            ref_keep[a]   = d;
            known_keep[a] = 1'b1;
            ref_clr[a]    = d;
        end
        bus_keep.wr_valid  = 1'b0;
        bus_keep.cmd_valid = 1'b0;
        if (n_beats == len + 1) check_idle_outputs("wr_end");
    endtask

    // mode 0: rd_ready held high, 1: pattern 1,0,0,1 repeating, 2: random.
    task automatic read_burst(input int addr, input int len, input int mode);
        int idx;
        int cyc;
        int a;
        bit rdy;
        bit stall;
        send_cmd(1'b0, addr, len);
        check_eq("rd_valid_first", bus_keep.rd_valid, 0);
        idx = 0;
        cyc = 0;
        while (idx <= len && cyc < 200) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? rdy_pat[cyc % 4] : 1'($urandom_range(0, 1));
            bus_keep.rd_ready = rdy;
            bus_keep.wr_valid = 1'($urandom_range(0, 1));
            bus_keep.wr_data  = DW'($urandom);
            check_eq("wr_ready_in_read", bus_keep.wr_ready, 0);
            if (bus_keep.rd_valid) begin
                a = (addr + idx) % MS;
                if (known_keep[a]) check_eq("rd_data_keep", bus_keep.rd_data, ref_keep[a]);
                check_eq("rd_data_clr", bus_clr.rd_data, ref_clr[a]);
            end
            stall = bus_keep.rd_valid && !rdy;
            if (bus_keep.rd_valid && rdy) idx++;
            step();
            cyc++;
            if (stall) check_eq("rd_valid_stall", bus_keep.rd_valid, 1);
        end
        bus_keep.rd_ready = 1'b0;
        bus_keep.wr_valid = 1'b0;
        check_eq("rd_words", idx, len + 1);
        if (mode == 0) check_eq("rd_cycles", cyc, len + 2);
        check_idle_outputs("rd_end");
    endtask

    initial begin
        bus_keep.cmd_valid = 1'b0;
        bus_keep.cmd_write = 1'b0;
        bus_keep.cmd_addr  = '0;
        bus_keep.cmd_len   = '0;
        bus_keep.wr_valid  = 1'b0;
        bus_keep.wr_data   = '0;
        bus_keep.rd_ready  = 1'b0;
        for (int i = 0; i < MS; i++) begin
            known_keep[i] = 1'b0;
            ref_keep[i]   = '0;
        end
        #12;
        apply_reset();

        // Sequential data, back-to-back readback.
        write_burst(4, 3, 4, 1'b1, 8'hA1, 1'b0);
        read_burst(4, 3, 0);

        // Address wrap at the top of memory.
        write_burst(62, 3, 4, 1'b0, 8'h00, 1'b0);
        read_burst(62, 3, 0);

        // Stalled readback.
        read_burst(62, 3, 1);

        // Write data offered in IDLE must not land anywhere.
        bus_keep.wr_valid = 1'b1;
        bus_keep.wr_data  = 8'hFF;
        check_eq("wr_ready_idle", bus_keep.wr_ready, 0);
        step();
        step();
        bus_keep.wr_valid = 1'b0;
        read_burst(4, 3, 2);

        // Command held during a busy write, then a single-word read.
        write_burst(10, 5, 6, 1'b0, 8'h00, 1'b1);
        read_burst(10, 5, 0);
        read_burst(12, 0, 0);
        read_burst(13, 0, 1);

        // Reset in the middle of a four-beat write.
        write_burst(20, 3, 2, 1'b1, 8'h51, 1'b0);
        apply_reset();
        read_burst(20, 1, 0);
        read_burst(4, 3, 0);

        for (int n = 0; n < 40; n++) begin
            int addr;
            int len;
            addr = int'($urandom_range(0, MS - 1));
            len  = int'($urandom_range(0, MB - 1));
            repeat ($urandom_range(0, 2)) step();
            if ($urandom_range(0, 1) == 1) write_burst(addr, len, len + 1, 1'b0, 8'h00, 1'b0);
            else read_burst(addr, len, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
